// File: rtl/simple_bus_pkg.sv
// Shared types and constants for the simple_bus arbiter slice.
// Bus modes, arbiter states and address/data widths.
package simple_bus_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'b00,
      MODE_READ  = 2'b01,
      MODE_WRITE = 2'b10,
      MODE_RSVD  = 2'b11
   } bus_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      BUSY,
      DONE
   } arb_state_e;

endpackage

// File: rtl/simple_bus_rr_pick.sv
// Combinational round-robin picker.
// Finds the first set request at or above ptr, wrapping around.
module simple_bus_rr_pick #(
   parameter int  NUM_M = 4,
   localparam int PW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
   input  logic [NUM_M-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [NUM_M-1:0] pick,
   output logic [PW-1:0]    idx,
   output logic             valid
);

   // scan upward from ptr, first hit wins
   always_comb begin
      int          j;
      logic [PW-1:0] jj;
      valid = 1'b0;
      idx   = '0;
      pick  = '0;
      j     = 0;
      jj    = '0;
      for (int i = 0; i < NUM_M; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_M) j = j - NUM_M;
         jj = PW'(j);
         if (!valid && req[jj]) begin
            valid = 1'b1;
            idx   = jj;
         end
      end
      if (valid) pick[idx] = 1'b1;
   end

endmodule

// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter sharing one simple_bus slave among NUM_M masters.
// Sequences grant, slave start, completion and timeout abort.
module simple_bus_arbiter
   import simple_bus_pkg::*;
#(
   parameter int NUM_M   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_M-1:0]        m_req,
   output logic [NUM_M-1:0]        m_gnt,
   input  logic [NUM_M-1:0]        m_start,
   input  logic [NUM_M*ADDR_W-1:0] m_addr,
   input  logic [NUM_M*2-1:0]      m_mode,
   input  logic [NUM_M*DATA_W-1:0] m_wdata,
   output logic [NUM_M-1:0]        m_rdy,
   output logic                    m_err,
   output logic [DATA_W-1:0]       m_rdata,
   output logic                    s_start,
   output logic [ADDR_W-1:0]       s_addr,
   output logic [1:0]              s_mode,
   output logic [DATA_W-1:0]       s_wdata,
   input  logic                    s_rdy,
   input  logic [DATA_W-1:0]       s_rdata
);

   localparam int            PW       = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [PW-1:0] LAST_M   = PW'(NUM_M - 1);

   arb_state_e          state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [PW-1:0]       win_q, win_d;
   logic [NUM_M-1:0]    gnt_q, gnt_d;
   logic [NUM_M-1:0]    rdy_q, rdy_d;
   logic [7:0]          timer_q, timer_d;
   logic                s_start_q, s_start_d;
   logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
   bus_mode_e           s_mode_q, s_mode_d;
   logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [NUM_M-1:0]    pick;
   logic [PW-1:0]       pick_idx;
   logic                pick_vld;

   logic                w_req;
   logic                w_start;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_wdata;
   bus_mode_e           w_mode;
   logic [PW-1:0]       w_next;

   simple_bus_rr_pick #(
      .NUM_M (NUM_M)
   ) u_pick (
      .req   (m_req),
      .ptr   (ptr_q),
      .pick  (pick),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   // select the current winner's request fields
   always_comb begin
      w_req   = m_req[win_q];
      w_start = m_start[win_q];
      w_addr  = m_addr[int'(win_q)*ADDR_W +: ADDR_W];
      w_wdata = m_wdata[int'(win_q)*DATA_W +: DATA_W];
      w_mode  = bus_mode_e'(m_mode[int'(win_q)*2 +: 2]);
      w_next  = (win_q == LAST_M) ? '0 : win_q + PW'(1);
   end

   // next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      win_d     = win_q;
      gnt_d     = gnt_q;
      timer_d   = timer_q;
      s_start_d = 1'b0;
      s_addr_d  = s_addr_q;
      s_mode_d  = s_mode_q;
      s_wdata_d = s_wdata_q;
      rdy_d     = '0;
      err_d     = 1'b0;
      rdata_d   = '0;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               gnt_d   = pick;
               win_d   = pick_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (w_start) begin
               if (w_mode == MODE_READ ||
                   w_mode == MODE_WRITE) begin
                  s_addr_d  = w_addr;
                  s_mode_d  = w_mode;
                  s_wdata_d = w_wdata;
                  s_start_d = 1'b1;
                  timer_d   = '0;
                  state_d   = BUSY;
               end else begin
                  rdy_d   = gnt_q;
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end else if (!w_req) begin
               gnt_d   = '0;
               ptr_d   = w_next;
               state_d = IDLE;
            end
         end
         BUSY: begin
            timer_d = timer_q + 8'd1;
            if (s_rdy) begin
               rdy_d   = gnt_q;
               rdata_d = (s_mode_q == MODE_READ) ? s_rdata : '0;
               state_d = DONE;
            end else if (timer_q == TMO_LAST) begin
               rdy_d   = gnt_q;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            gnt_d   = '0;
            ptr_d   = w_next;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         win_q     <= '0;
         gnt_q     <= '0;
         rdy_q     <= '0;
         timer_q   <= '0;
         s_start_q <= 1'b0;
         s_addr_q  <= '0;
         s_mode_q  <= MODE_IDLE;
         s_wdata_q <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         gnt_q     <= gnt_d;
         rdy_q     <= rdy_d;
         timer_q   <= timer_d;
         s_start_q <= s_start_d;
         s_addr_q  <= s_addr_d;
         s_mode_q  <= s_mode_d;
         s_wdata_q <= s_wdata_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign m_gnt   = gnt_q;
   assign m_rdy   = rdy_q;
   assign m_err   = err_q;
   assign m_rdata = rdata_q;
   assign s_start = s_start_q;
   assign s_addr  = s_addr_q;
   assign s_mode  = s_mode_q;
   assign s_wdata = s_wdata_q;

endmodule
